adc_serial_responder: RTL and testbench



---
 rtl/adc_serial_pkg.sv | 21 ++
 rtl/sync_edge.sv | 36 +++
 rtl/adc_serial_responder.sv | 169 ++++++++++++++++
 tb/tb_adc_serial_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_pkg.sv
// adc_serial_pkg: definitions shared by the serial ADC responder and the ADC
// reader that talks to it.
//   SAMPLE_WIDTH - data bits per frame
//   LEAD_ZEROS   - zero bits shifted out ahead of the data
//   FRAME_BITS   - total bits per chip-select frame
//   CNT_W        - width of a counter that can hold FRAME_BITS-1
//   adc_state_t  - responder frame state
package adc_serial_pkg;

    localparam int SAMPLE_WIDTH = 12;
    localparam int LEAD_ZEROS   = 4;
    localparam int FRAME_BITS   = LEAD_ZEROS + SAMPLE_WIDTH;
    localparam int CNT_W        = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } adc_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: STAGES-deep synchroniser for an asynchronous input, with
// rise/fall pulses derived from the last stage and one further registered copy.
//   i_clk    - system clock
//   i_reset  - synchronous, active-high; all flops load RST_VAL
//   i_async  - asynchronous input
//   o_rise   - one-cycle pulse on a synchronised 0->1 transition
//   o_fall   - one-cycle pulse on a synchronised 1->0 transition
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Resetting to the idle level keeps a reset from looking like an edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: responder end of a 3-wire serial ADC link, emulating a
// 12-bit AD7476-style converter. Each chip-select frame shifts out LEAD_ZEROS
// zeros followed by one sample, MSB first, advancing on adc_clk falling edges.
//   i_clk, i_reset        - system clock (>= 8x adc_clk), sync active-high reset
//   i_adc_clk, i_adc_cs   - asynchronous serial clock (idles high) / CS (active low)
//   o_adc_sd, o_adc_sd_oe - serial data and its tristate enable
//   i_sample_data/valid, o_sample_ready - 1-deep sample holding register
//   o_frame_done          - pulse when all FRAME_BITS have been shifted
//   o_frame_abort         - pulse when CS rises mid-frame
//   o_underrun            - sticky: a frame started with no sample held
module adc_serial_responder
    import adc_serial_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_adc_clk,
    input  logic                    i_adc_cs,
    output logic                    o_adc_sd,
    output logic                    o_adc_sd_oe,
    input  logic [SAMPLE_WIDTH-1:0] i_sample_data,
    input  logic                    i_sample_valid,
    output logic                    o_sample_ready,
    output logic                    o_frame_done,
    output logic                    o_frame_abort,
    output logic                    o_underrun
);

    adc_state_t                r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]     r_shift, w_shift_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic                      r_sd, w_sd_nxt;
    logic                      r_oe, w_oe_nxt;
    logic [SAMPLE_WIDTH-1:0]   r_hold;
    logic                      r_hold_vld;
    logic [SAMPLE_WIDTH-1:0]   r_last, w_last_nxt;
    logic                      r_underrun, w_underrun_nxt;
    logic                      r_done, w_done_nxt;
    logic                      r_abort, w_abort_nxt;
    logic                      w_consume;
    logic                      w_load;
    logic [SAMPLE_WIDTH-1:0]   w_pick;
    logic                      w_clk_fall;
    logic                      w_cs_rise, w_cs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_adc_clk),
        .o_rise  (),
        .o_fall  (w_clk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_adc_cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    assign w_load = i_sample_valid && !r_hold_vld;
    // With nothing held, the previous sample is resent (underrun).
    assign w_pick = r_hold_vld ? r_hold : r_last;

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_sd_nxt       = r_sd;
        w_oe_nxt       = r_oe;
        w_last_nxt     = r_last;
        w_underrun_nxt = r_underrun;
        w_done_nxt     = 1'b0;
        w_abort_nxt    = 1'b0;
        w_consume      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sd_nxt = 1'b0;
                w_oe_nxt = 1'b0;
                // adc_clk is deliberately ignored here, including an edge
                // coinciding with the CS fall.
                if (w_cs_fall) begin
                    w_consume      = r_hold_vld;
                    w_underrun_nxt = r_underrun | ~r_hold_vld;
                    w_last_nxt     = w_pick;
                    w_shift_nxt    = {{LEAD_ZEROS{1'b0}}, w_pick};
                    w_sd_nxt       = w_shift_nxt[FRAME_BITS-1];
                    w_oe_nxt       = 1'b1;
                    w_cnt_nxt      = CNT_W'(FRAME_BITS - 1);
                    w_state_nxt    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_sd_nxt    = 1'b0;
                    w_oe_nxt    = 1'b0;
                    w_abort_nxt = 1'b1;
                end else if (w_clk_fall) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_TAIL;
                        w_sd_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
                        w_sd_nxt    = r_shift[FRAME_BITS-2];
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end
                end
            end
            ST_TAIL: begin
                w_sd_nxt = 1'b0;
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_oe_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sd_nxt    = 1'b0;
                w_oe_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_sd       <= 1'b0;
            r_oe       <= 1'b0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_last     <= '0;
            r_underrun <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sd       <= w_sd_nxt;
            r_oe       <= w_oe_nxt;
            r_last     <= w_last_nxt;
            r_underrun <= w_underrun_nxt;
            r_done     <= w_done_nxt;
            r_abort    <= w_abort_nxt;
            // A load can only coincide with an underrun frame start (register
            // empty); the frame takes the last sample and the new one stays.
            if (w_load) begin
                r_hold     <= i_sample_data;
                r_hold_vld <= 1'b1;
            end else if (w_consume) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    assign o_adc_sd       = r_sd;
    assign o_adc_sd_oe    = r_oe;
    assign o_sample_ready = ~r_hold_vld;
    assign o_frame_done   = r_done;
    assign o_frame_abort  = r_abort;
    assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: drives the serial link as an initiator
// (adc_clk = clk/8) and compares every observed bit, pulse and flag against a
// frame-level model (sample queue, last-sample value, sticky underrun).
module tb_adc_serial_responder;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        adc_clk = 1'b1;
    logic        adc_cs  = 1'b1;
    logic        s_valid = 1'b0;
    logic [11:0] s_data  = 12'h000;
    logic        adc_sd, sd_oe, s_ready, f_done, f_abort, underrun;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    logic [11:0] mq[$];
    logic [11:0] m_last  = 12'h000;
    logic        m_under = 1'b0;
    logic [15:0] got;

    always #5 clk = ~clk;

    adc_serial_responder #(.SYNC_STAGES(2)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_adc_clk      (adc_clk),
        .i_adc_cs       (adc_cs),
        .o_adc_sd       (adc_sd),
        .o_adc_sd_oe    (sd_oe),
        .i_sample_data  (s_data),
        .i_sample_valid (s_valid),
        .o_sample_ready (s_ready),
        .o_frame_done   (f_done),
        .o_frame_abort  (f_abort),
        .o_underrun     (underrun)
    );

    always @(negedge clk) begin
        if (f_done)  done_cnt++;
        if (f_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle valid pulse; the model accepts it only if nothing is held.
    task automatic push_now(input logic [11:0] v);
        bit acc;
        acc = (mq.size() == 0);
        chk("ready_at_push", {31'b0, s_ready}, {31'b0, acc});
        s_valid = 1'b1;
        s_data  = v;
        wait_cyc(1);
        s_valid = 1'b0;
        if (acc) mq.push_back(v);
    endtask

    function automatic logic exp_bit(input logic [15:0] w, input int k);
        if (k < 16) return w[15-k];
        return 1'b0;
    endfunction

    // Frame of nf falling adc_clk edges. both: adc_clk falls with CS.
    // mid: push mv during the frame. rst_end: finish with reset instead of CS rise.
    task automatic run_frame(input int nf, input bit both, input bit mid,
                             input logic [11:0] mv, input bit rst_end);
        logic [11:0] s;
        logic [15:0] w;
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        adc_cs = 1'b0;
        if (both) adc_clk = 1'b0;
        wait_cyc(2);
        chk("cs_lat_pre", {31'b0, sd_oe}, 32'd0);
        wait_cyc(1);
        if (mq.size() > 0) s = mq.pop_front();
        else begin
            s = m_last;
            m_under = 1'b1;
        end
        m_last = s;
        w = {4'b0000, s};
        chk("cs_lat_oe", {31'b0, sd_oe}, 32'd1);
        chk("bit0", {31'b0, adc_sd}, {31'b0, w[15]});
        chk("underrun", {31'b0, underrun}, {31'b0, m_under});
        chk("ready_start", {31'b0, s_ready}, {31'b0, mq.size() == 0});
        got = 16'h0;
        got[15] = adc_sd;
        if (both) begin
            wait_cyc(2);
            adc_clk = 1'b1;
            wait_cyc(4);
            chk("both_no_shift", {31'b0, adc_sd}, {31'b0, w[15]});
        end
        for (int k = 1; k <= nf; k++) begin
            adc_clk = 1'b0;
            wait_cyc(2);
            chk("sd_hold", {31'b0, adc_sd}, {31'b0, exp_bit(w, k-1)});
            wait_cyc(1);
            chk("sd_bit", {31'b0, adc_sd}, {31'b0, exp_bit(w, k)});
            if (k < 16) got[15-k] = adc_sd;
            wait_cyc(1);
            adc_clk = 1'b1;
            if (mid && k == 2) begin
                wait_cyc(1);
                push_now(mv);
                wait_cyc(1);
            end else begin
                wait_cyc(3);
            end
            chk("sd_rise", {31'b0, adc_sd}, {31'b0, exp_bit(w, k)});
            chk("oe_frame", {31'b0, sd_oe}, 32'd1);
            chk("ready_frame", {31'b0, s_ready}, {31'b0, mq.size() == 0});
            wait_cyc(1);
        end
        if (nf >= 16) begin
            chk("word", {16'h0, got}, {16'h0, w});
            chk("sample", {20'h0, got[11:0]}, {20'h0, s});
        end
        if (rst_end) begin
            reset   = 1'b1;
            adc_cs  = 1'b1;
            adc_clk = 1'b1;
            wait_cyc(1);
            chk("rst_sd", {31'b0, adc_sd}, 32'd0);
            chk("rst_oe", {31'b0, sd_oe}, 32'd0);
            chk("rst_ready", {31'b0, s_ready}, 32'd1);
            chk("rst_underrun", {31'b0, underrun}, 32'd0);
            wait_cyc(3);
            reset = 1'b0;
            mq.delete();
            m_last  = 12'h000;
            m_under = 1'b0;
            wait_cyc(2);
        end else begin
            adc_cs = 1'b1;
            wait_cyc(2);
            chk("cs_rise_pre", {31'b0, sd_oe}, 32'd1);
            wait_cyc(1);
            chk("cs_rise_oe", {31'b0, sd_oe}, 32'd0);
            chk("cs_rise_sd", {31'b0, adc_sd}, 32'd0);
            wait_cyc(2);
            chk("done_cnt", done_cnt, d0 + ((nf >= 16) ? 1 : 0));
            chk("abort_cnt", abort_cnt, a0 + ((nf < 16) ? 1 : 0));
        end
        wait_cyc(4);
    endtask

    initial begin
        int nf;
        wait_cyc(3);
        chk("rst0_sd", {31'b0, adc_sd}, 32'd0);
        chk("rst0_oe", {31'b0, sd_oe}, 32'd0);
        chk("rst0_ready", {31'b0, s_ready}, 32'd1);
        chk("rst0_done", {31'b0, f_done}, 32'd0);
        chk("rst0_abort", {31'b0, f_abort}, 32'd0);
        chk("rst0_underrun", {31'b0, underrun}, 32'd0);
        reset = 1'b0;
        wait_cyc(3);

        // Basic frame
        push_now(12'hA5C);
        chk("ready_held", {31'b0, s_ready}, 32'd0);
        run_frame(16, 1'b0, 1'b0, 12'h000, 1'b0);

        // Back-to-back: second push while the first frame is running
        push_now(12'h001);
        run_frame(16, 1'b0, 1'b1, 12'hFFF, 1'b0);
        run_frame(16, 1'b0, 1'b0, 12'h000, 1'b0);

        // Underrun: one sample, three frames
        push_now(12'h123);
        run_frame(16, 1'b0, 1'b0, 12'h000, 1'b0);
        run_frame(16, 1'b0, 1'b0, 12'h000, 1'b0);
        run_frame(16, 1'b0, 1'b0, 12'h000, 1'b0);

        // Abort after 7 edges, then the queued sample follows
        push_now(12'h3C5);
        run_frame(7, 1'b0, 1'b1, 12'h2B4, 1'b0);
        run_frame(16, 1'b0, 1'b0, 12'h000, 1'b0);

        // adc_clk activity with CS high is ignored
        for (int i = 0; i < 3; i++) begin
            adc_clk = 1'b0;
            wait_cyc(4);
            adc_clk = 1'b1;
            wait_cyc(4);
        end
        chk("idle_clk_oe", {31'b0, sd_oe}, 32'd0);
        chk("idle_clk_sd", {31'b0, adc_sd}, 32'd0);

        // Extra edges in the tail, and CS/adc_clk falling together
        push_now(12'h9D2);
        run_frame(19, 1'b0, 1'b0, 12'h000, 1'b0);
        push_now(12'h6B1);
        run_frame(16, 1'b1, 1'b0, 12'h000, 1'b0);

        // Reset after bit 9 with a sample queued
        push_now(12'h4C8);
        run_frame(9, 1'b0, 1'b1, 12'h7E7, 1'b1);
        run_frame(16, 1'b0, 1'b0, 12'h000, 1'b0);

        // Randomized frames
        for (int i = 0; i < 24; i++) begin
            if (mq.size() == 0 && $urandom_range(0, 2) != 0)
                push_now(12'($urandom));
            nf = int'($urandom_range(3, 20));
            run_frame(nf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      12'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
